// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command link (accumulator and serializer).
package uart_cmd_pkg;

  localparam logic [7:0] TERM_BYTE_0   = 8'hBE;
  localparam logic [7:0] TERM_BYTE_1   = 8'hEF;
  localparam int         MAX_CMD_BYTES = 128;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PAYLOAD = 3'd1,
    CHK     = 3'd2,
    TERM0   = 3'd3,
    TERM1   = 3'd4
  } ser_state_t;

endpackage

// File: rtl/uart_tx_stall_timer.sv
// Counts consecutive stalled cycles on the TX handshake; expired fires on the
// TIMEOUT-th stalled cycle so the owner can abort at that clock edge.
module uart_tx_stall_timer #(
  parameter int TIMEOUT = 2000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (count_en) begin
      count <= count + CW'(1);
    end else begin
      count <= count;
    end
  end

  assign expired = count_en && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/uart_command_serializer.sv
// Emits a buffered command byte-by-byte over valid/ready, followed by BE EF.
// Define CMD_SER_CHECKSUM_EN to insert an XOR checksum byte before the terminator.
module uart_command_serializer
  import uart_cmd_pkg::*;
#(
  parameter int MAX_BYTES = MAX_CMD_BYTES,
  parameter int TIMEOUT   = 2000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [8*MAX_BYTES-1:0] input_data,
  input  logic [7:0]             input_data_size,
  input  logic                   start,
  input  logic                   tx_ready,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);

  localparam int IW = $clog2(MAX_BYTES) + 1;
  localparam logic [8:0] MAX_SIZE = 9'(MAX_BYTES);
`ifdef CMD_SER_CHECKSUM_EN
  localparam ser_state_t AFTER_PAYLOAD = CHK;
`else
  localparam ser_state_t AFTER_PAYLOAD = TERM0;
`endif

  ser_state_t             state, state_next;
  logic [IW-1:0]          idx, idx_next;
  logic [7:0]             size_q, size_next;
  logic [8*MAX_BYTES-1:0] payload_q, payload_next;
  logic [7:0]             tx_data_next;
  logic                   tx_valid_next, busy_next, done_next, error_next;
  logic                   hs, expired;
  logic [7:0]             chk_next;
`ifdef CMD_SER_CHECKSUM_EN
  logic [7:0]             chk_q;
`endif

  assign hs = tx_valid && tx_ready;

  uart_tx_stall_timer #(.TIMEOUT(TIMEOUT)) u_stall_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (hs || !tx_valid),
    .count_en (tx_valid && !tx_ready),
    .expired  (expired)
  );

  always_comb begin
    state_next   = state;
    idx_next     = idx;
    size_next    = size_q;
    payload_next = payload_q;
    error_next   = error;
    done_next    = 1'b0;
`ifdef CMD_SER_CHECKSUM_EN
    chk_next     = chk_q;
`else
    chk_next     = 8'h00;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          if ({1'b0, input_data_size} > MAX_SIZE) begin
            error_next = 1'b1;
          end else begin
            error_next   = 1'b0;
            payload_next = input_data;
            size_next    = input_data_size;
            idx_next     = '0;
            chk_next     = 8'h00;
            state_next   = (input_data_size == 8'd0) ? AFTER_PAYLOAD : PAYLOAD;
          end
        end else begin
          state_next = IDLE;
        end
      end
      PAYLOAD: begin
        if (hs) begin
          chk_next = chk_next ^ tx_data;
          idx_next = idx + IW'(1);
          if (idx + IW'(1) == IW'(size_q)) begin
            state_next = AFTER_PAYLOAD;
          end else begin
            state_next = PAYLOAD;
          end
        end else begin
          state_next = PAYLOAD;
        end
      end
`ifdef CMD_SER_CHECKSUM_EN
      CHK: begin
        if (hs) begin
          state_next = TERM0;
        end else begin
          state_next = CHK;
        end
      end
`endif
      TERM0: begin
        if (hs) begin
          state_next = TERM1;
        end else begin
          state_next = TERM0;
        end
      end
      TERM1: begin
        if (hs) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else begin
          state_next = TERM1;
        end
      end
      default: state_next = IDLE;
    endcase

    // A stall timeout overrides whatever the frame was doing.
    if (state != IDLE && expired) begin
      state_next = IDLE;
      error_next = 1'b1;
      done_next  = 1'b0;
    end else begin
      state_next = state_next;
    end

    tx_valid_next = 1'b1;
    case (state_next)
      PAYLOAD: tx_data_next = payload_next[{idx_next, 3'b000} +: 8];
      CHK:     tx_data_next = chk_next;
      TERM0:   tx_data_next = TERM_BYTE_0;
      TERM1:   tx_data_next = TERM_BYTE_1;
      default: begin
        tx_data_next  = 8'h00;
        tx_valid_next = 1'b0;
      end
    endcase
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      size_q    <= 8'h00;
      payload_q <= '0;
      tx_data   <= 8'h00;
      tx_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      state     <= state_next;
      idx       <= idx_next;
      size_q    <= size_next;
      payload_q <= payload_next;
      tx_data   <= tx_data_next;
      tx_valid  <= tx_valid_next;
      busy      <= busy_next;
      done      <= done_next;
      error     <= error_next;
    end
  end

`ifdef CMD_SER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      chk_q <= 8'h00;
    end else begin
      chk_q <= chk_next;
    end
  end
`endif

endmodule

// File: tb/tb_uart_command_serializer.sv
// Scoreboard bench: expected bytes are queued by the stimulus, a monitor pops on every handshake.
module tb_uart_command_serializer;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1023:0] in_data = '0;
  logic [7:0]    in_size = 8'd0;
  logic          start = 1'b0;
  logic          tx_ready = 1'b0;
  logic [7:0]    tx_data;
  logic          tx_valid, busy, done, error;

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];
  logic       stab_en = 1'b1;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always #5 clk = ~clk;

  uart_command_serializer #(.MAX_BYTES(128), .TIMEOUT(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .input_data      (in_data),
    .input_data_size (in_size),
    .start           (start),
    .tx_ready        (tx_ready),
    .tx_data         (tx_data),
    .tx_valid        (tx_valid),
    .busy            (busy),
    .done            (done),
    .error           (error)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor and hold-stability monitor.
  always @(negedge clk) begin
    if (!reset && stab_en && prev_stall) begin
      check("hold_valid", 32'(tx_valid), 32'd1);
      check("hold_data", 32'(tx_data), 32'(prev_data));
    end
    if (!reset && tx_valid && tx_ready) begin
      check("sb_has_entry", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check("sb_byte", 32'(tx_data), 32'(exp_q.pop_front()));
    end
    prev_stall = !reset && tx_valid && !tx_ready;
    prev_data  = tx_data;
  end

  task automatic do_start(input logic [7:0] sz);
    @(posedge clk); #1;
    in_size = sz;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check(name, 32'(seen), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(tx_valid), 32'd0);
    check("rst_data", 32'(tx_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // 1: three bytes, ready held high
    tx_ready = 1'b1;
    in_data = '0;
    in_data[23:0] = 24'h332211;
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
`ifdef CMD_SER_CHECKSUM_EN
    exp_q.push_back(8'h00);
`endif
    exp_q.push_back(8'hBE); exp_q.push_back(8'hEF);
    do_start(8'd3);
    @(negedge clk);
    check("t1_first_valid", 32'(tx_valid), 32'd1);
    check("t1_first_byte", 32'(tx_data), 32'h11);
    check("t1_busy", 32'(busy), 32'd1);
`ifdef CMD_SER_CHECKSUM_EN
    repeat (5) @(negedge clk);
`else
    repeat (4) @(negedge clk);
`endif
    check("t1_done_early", 32'(done), 32'd0);
    @(negedge clk);
    check("t1_done", 32'(done), 32'd1);
    check("t1_busy_end", 32'(busy), 32'd0);
    check("t1_error", 32'(error), 32'd0);
    check("t1_sb_empty", 32'(exp_q.size()), 32'd0);

    // 2: empty payload
`ifdef CMD_SER_CHECKSUM_EN
    exp_q.push_back(8'h00);
`endif
    exp_q.push_back(8'hBE); exp_q.push_back(8'hEF);
    do_start(8'd0);
    wait_done("t2_done", 10);
    check("t2_error", 32'(error), 32'd0);
    check("t2_sb_empty", 32'(exp_q.size()), 32'd0);

    // 3: two bytes with tx_ready toggling every cycle
    in_data = '0;
    in_data[15:0] = 16'h5AA5;
    exp_q.push_back(8'hA5); exp_q.push_back(8'h5A);
`ifdef CMD_SER_CHECKSUM_EN
    exp_q.push_back(8'hFF);
`endif
    exp_q.push_back(8'hBE); exp_q.push_back(8'hEF);
    tx_ready = 1'b0;
    do_start(8'd2);
    for (int i = 0; i < 40; i++) begin
      if (done) break;
      @(posedge clk); #1;
      tx_ready = ~tx_ready;
    end
    check("t3_done_seen", 32'(exp_q.size()), 32'd0);
    tx_ready = 1'b1;
    repeat (2) @(posedge clk);

    // 4: oversize request, then recovery
    do_start(8'd129);
    @(negedge clk);
    check("t4_error", 32'(error), 32'd1);
    check("t4_valid", 32'(tx_valid), 32'd0);
    check("t4_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("t4_valid_later", 32'(tx_valid), 32'd0);
    in_data = '0;
    in_data[7:0] = 8'h7E;
    exp_q.push_back(8'h7E);
`ifdef CMD_SER_CHECKSUM_EN
    exp_q.push_back(8'h7E);
`endif
    exp_q.push_back(8'hBE); exp_q.push_back(8'hEF);
    do_start(8'd1);
    @(negedge clk);
    check("t4_error_cleared", 32'(error), 32'd0);
    wait_done("t4_done", 10);

    // 5: permanent stall -> timeout after 16 cycles
    stab_en = 1'b0;
    tx_ready = 1'b0;
    in_data = '0;
    in_data[7:0] = 8'h42;
    do_start(8'd1);
    repeat (16) @(negedge clk);
    check("t5_valid_at_16", 32'(tx_valid), 32'd1);
    check("t5_error_at_16", 32'(error), 32'd0);
    @(negedge clk);
    check("t5_valid_dropped", 32'(tx_valid), 32'd0);
    check("t5_error", 32'(error), 32'd1);
    check("t5_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t5_no_done", 32'(done), 32'd0);
    end
    stab_en = 1'b1;

    // 6: start while busy ignored, then reset mid-payload
    tx_ready = 1'b1;
    in_data = '0;
    in_data[23:0] = 24'h030201;
    exp_q.push_back(8'h01);
    do_start(8'd3);
    @(negedge clk);
    @(posedge clk); #1;
    tx_ready = 1'b0;
    in_size = 8'd0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("t6_busy_start_ignored", 32'(tx_data), 32'h02);
    check("t6_valid_held", 32'(tx_valid), 32'd1);
    check("t6_error_kept", 32'(error), 32'd0);
    stab_en = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("t6_rst_valid", 32'(tx_valid), 32'd0);
    check("t6_rst_data", 32'(tx_data), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_done", 32'(done), 32'd0);
    check("t6_rst_error", 32'(error), 32'd0);
    reset = 1'b0;
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t6_idle_after_rst", 32'(tx_valid), 32'd0);
    end
    stab_en = 1'b1;
    check("final_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
